reorder_request_tagger: RTL and testbench

//  Upstream issue stage for reorder_queue. Accepts in-order read requests, stamps each with the queue's

---
 rtl/reorder_request_tagger_pkg.sv | 16 +
 rtl/reorder_request_tagger.sv | 110 +++++++++++
 tb/tb_reorder_request_tagger.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_request_tagger_pkg.sv
// Shared types and helpers for the reorder request tagger.
// Holds the issue-stage state encoding and the tag width rule.
package reorder_request_tagger_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Tag carries the queue index plus one wrap bit.
  function automatic int tag_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reorder_request_tagger.sv
// Tags in-order requests with the reorder queue index and packs tagged responses for the queue.
// Latency: request to memory port 1 cycle, response to queue write 1 cycle.
// Backpressure: req_ready drops when the queue is full, the held request stalls, or not in RUN.
module reorder_request_tagger
  import reorder_request_tagger_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int TAG_WIDTH   = tag_width(DEPTH),
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 57,
  parameter int INIT_CYCLES = DEPTH + 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  output logic                            req_ready,
  input  logic                            flush,
  output logic                            mem_req_valid,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [TAG_WIDTH-1:0]            mem_req_tag,
  input  logic                            mem_req_stall,
  input  logic                            mem_rsp_valid,
  input  logic [TAG_WIDTH-1:0]            mem_rsp_tag,
  input  logic [DATA_WIDTH-1:0]           mem_rsp_data,
  output logic                            rq_increment,
  input  logic [TAG_WIDTH-1:0]            rq_index_tag,
  input  logic                            rq_full,
  output logic                            rq_wr_en,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] rq_d,
  output logic [TAG_WIDTH:0]              outstanding,
  output logic                            idle,
  output logic                            error
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [TAG_WIDTH:0] OUT_ONE  = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] init_cnt;
  logic             accept;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_cnt == CNT_LAST) state_nxt = ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!flush) state_nxt = ST_RUN;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT && state_nxt == ST_INIT) init_cnt <= init_cnt + CNT_ONE;
    end
  end

  // The queue's end pointer advances on the same edge that captures its current index.
  assign req_ready    = (state == ST_RUN) && !rq_full && !(mem_req_valid && mem_req_stall);
  assign accept       = req_valid && req_ready;
  assign rq_increment = accept;
  assign idle         = (state == ST_DRAIN) && (outstanding == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_tag   <= '0;
    end else if (accept) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= req_addr;
      mem_req_tag   <= rq_index_tag;
    end else if (!mem_req_stall) begin
      mem_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wr_en <= 1'b0;
      rq_d     <= '0;
    end else begin
      rq_wr_en <= mem_rsp_valid;
      if (mem_rsp_valid) rq_d <= {mem_rsp_data, mem_rsp_tag};
    end
  end

  // A stray response is still forwarded; it only flags the error and leaves the count at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      error       <= 1'b0;
    end else begin
      if (mem_rsp_valid && outstanding == '0) error <= 1'b1;
      if (accept && !mem_rsp_valid) begin
        outstanding <= outstanding + OUT_ONE;
      end else if (mem_rsp_valid && !accept && outstanding != '0) begin
        outstanding <= outstanding - OUT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reorder_request_tagger.sv
// Randomised bench for reorder_request_tagger with a queue/memory model held in the bench.
module tb_reorder_request_tagger;

  localparam int DEPTH = 8;
  localparam int TW    = 4;
  localparam int AW    = 48;
  localparam int DW    = 57;
  localparam int INIT  = 10;
  localparam int RQW   = DW + TW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic           req_ready;
  logic           flush = 1'b0;
  logic           mem_req_valid;
  logic [AW-1:0]  mem_req_addr;
  logic [TW-1:0]  mem_req_tag;
  logic           mem_req_stall = 1'b0;
  logic           mem_rsp_valid = 1'b0;
  logic [TW-1:0]  mem_rsp_tag = '0;
  logic [DW-1:0]  mem_rsp_data = '0;
  logic           rq_increment;
  logic [TW-1:0]  rq_index_tag;
  logic           rq_full;
  logic           rq_wr_en;
  logic [RQW-1:0] rq_d;
  logic [TW:0]    outstanding;
  logic           idle;
  logic           error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs must be after the edges seen so far.
  int            m_edges;
  bit            m_drain;
  bit            m_mvalid;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_tag;
  bit            m_wr;
  logic [RQW-1:0] m_rqd;
  int            m_out;
  bit            m_err;
  logic [TW-1:0] m_next_tag;
  logic [TW-1:0] pend[$];
  bit            force_full = 1'b0;

  assign rq_index_tag = m_next_tag;
  assign rq_full      = (m_out >= DEPTH) || force_full;

  reorder_request_tagger #(
    .DEPTH(DEPTH), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag), .mem_req_stall(mem_req_stall), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data), .rq_increment(rq_increment),
    .rq_index_tag(rq_index_tag), .rq_full(rq_full), .rq_wr_en(rq_wr_en), .rq_d(rq_d),
    .outstanding(outstanding), .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (m_edges >= INIT) && !m_drain && !rq_full && !(m_mvalid && mem_req_stall);
  endfunction

  task automatic model_reset();
    m_edges = 0; m_drain = 0; m_mvalid = 0; m_addr = '0; m_tag = '0;
    m_wr = 0; m_rqd = '0; m_out = 0; m_err = 0; m_next_tag = '0;
    pend.delete();
  endtask

  task automatic model_step();
    bit acc;
    if (rst) return;
    acc = req_valid && exp_ready();
    if (m_mvalid && !mem_req_stall) pend.push_back(m_tag);
    if (m_edges < INIT) m_edges++;
    else m_drain = flush;
    if (acc) begin
      m_mvalid = 1; m_addr = req_addr; m_tag = m_next_tag; m_next_tag = m_next_tag + 1'b1;
    end else if (!mem_req_stall) begin
      m_mvalid = 0;
    end
    m_wr = mem_rsp_valid;
    if (mem_rsp_valid) m_rqd = {mem_rsp_data, mem_rsp_tag};
    if (mem_rsp_valid && m_out == 0) m_err = 1;
    if (acc && !mem_rsp_valid) m_out++;
    else if (mem_rsp_valid && !acc && m_out > 0) m_out--;
  endtask

  // Single compare point per cycle, between the input update and the next edge.
  always @(negedge clk) begin
    #2;
    check("req_ready",     64'(req_ready),     64'(exp_ready()));
    check("rq_increment",  64'(rq_increment),  64'(req_valid && exp_ready()));
    check("mem_req_valid", 64'(mem_req_valid), 64'(m_mvalid));
    check("mem_req_addr",  64'(mem_req_addr),  64'(m_addr));
    check("mem_req_tag",   64'(mem_req_tag),   64'(m_tag));
    check("rq_wr_en",      64'(rq_wr_en),      64'(m_wr));
    check("rq_d",          64'(rq_d),          64'(m_rqd));
    check("outstanding",   64'(outstanding),   64'(m_out));
    check("error",         64'(error),         64'(m_err));
    check("idle",          64'(idle),          64'((m_edges >= INIT) && m_drain && m_out == 0));
  end

  task automatic tick();
    @(posedge clk);
    #1 model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    req_addr = r[AW-1:0];
  endtask

  task automatic pick_rsp();
    logic [63:0] r;
    int i;
    if (pend.size() == 0) begin
      mem_rsp_valid = 0;
      return;
    end
    i = $urandom_range(0, pend.size() - 1);
    r = {$urandom, $urandom};
    mem_rsp_tag = pend[i];
    mem_rsp_data = r[DW-1:0];
    mem_rsp_valid = 1;
    pend.delete(i);
  endtask

  task automatic quiet();
    req_valid = 0; mem_rsp_valid = 0; mem_req_stall = 0; flush = 0; force_full = 0;
  endtask

  task automatic drain();
    int g = 0;
    req_valid = 0;
    while (m_out > 0 && g < 60) begin
      pick_rsp();
      tick();
      g++;
    end
    mem_rsp_valid = 0;
    check("drain_timeout", 64'(g >= 60), 64'(0));
  endtask

  task automatic fill_to(input int n);
    int g = 0;
    while (m_out < n && g < 40) begin
      req_valid = 1; rand_addr();
      tick();
      g++;
    end
    req_valid = 0;
    check("fill_timeout", 64'(g >= 40), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1; model_reset(); quiet();
    tick(); tick();
    rst = 0;
  endtask

  task automatic wait_init(output int lows);
    lows = 0;
    req_valid = 1; rand_addr();
    #2;
    while (!req_ready && lows < 30) begin
      tick();
      lows++;
      #2;
    end
  endtask

  initial begin
    int lows;
    logic [AW-1:0] held_addr;
    model_reset();
    do_reset();

    // Ready is held low for the whole init sweep; first tag issued is 0.
    wait_init(lows);
    check("init_ready_low_cycles", 64'(lows), 64'(10));
    check("first_increment", 64'(rq_increment), 64'(1));
    tick();
    req_valid = 0;
    #2;
    check("first_tag", 64'(mem_req_tag), 64'(0));
    check("first_valid", 64'(mem_req_valid), 64'(1));

    // Fill the queue, then one response frees a slot.
    fill_to(DEPTH);
    #2;
    check("full_outstanding", 64'(outstanding), 64'(8));
    check("full_ready", 64'(req_ready), 64'(0));
    check("full_last_tag", 64'(mem_req_tag), 64'(7));
    pick_rsp();
    tick();
    mem_rsp_valid = 0;
    #2;
    check("ready_after_rsp", 64'(req_ready), 64'(1));
    drain();

    // Held request while the memory port stalls.
    req_valid = 1; rand_addr(); held_addr = req_addr;
    tick();
    mem_req_stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_addr();
      #2;
      check("stall_addr_held", 64'(mem_req_addr), 64'(held_addr));
      check("stall_ready", 64'(req_ready), 64'(0));
      check("stall_no_incr", 64'(rq_increment), 64'(0));
      tick();
    end
    quiet();
    drain();

    // Accept and response together leave the count unchanged.
    fill_to(4);
    req_valid = 1; rand_addr(); pick_rsp();
    tick();
    quiet();
    #2;
    check("same_cycle_outstanding", 64'(outstanding), 64'(4));
    drain();
    tick();
    mem_rsp_valid = 1; mem_rsp_tag = 4'd5; mem_rsp_data = '0;
    tick();
    mem_rsp_valid = 0;
    #2;
    check("stray_error", 64'(error), 64'(1));
    check("stray_forwarded", 64'(rq_wr_en), 64'(1));

    // Reset mid-burst clears counts and the sticky error.
    fill_to(3);
    req_valid = 1; rand_addr();
    rst = 1; model_reset();
    #1;
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_valid", 64'(mem_req_valid), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    quiet();
    tick(); tick();
    rst = 0;
    wait_init(lows);
    check("reinit_ready_low_cycles", 64'(lows), 64'(10));
    req_valid = 0;

    // Flush with five outstanding drains to idle.
    fill_to(5);
    flush = 1;
    tick();
    req_valid = 1; rand_addr();
    #2;
    check("flush_ready", 64'(req_ready), 64'(0));
    check("flush_not_idle", 64'(idle), 64'(0));
    req_valid = 0;
    drain();
    #2;
    check("flush_idle", 64'(idle), 64'(1));
    flush = 0;
    tick();

    // Random traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      rand_addr();
      mem_req_stall = ($urandom_range(0, 4) == 0);
      force_full = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) flush = !flush;
      if ($urandom_range(0, 9) < 4) pick_rsp();
      else mem_rsp_valid = 0;
      if (c == 1500) begin
        rst = 1; model_reset();
        tick(); tick();
        rst = 0;
      end
      tick();
    end
    quiet();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
